// File: rtl/ascon_block_loader_pkg.sv
// Shared types and constants for the Ascon-128 block loader.
package ascon_block_loader_pkg;

  localparam int          RATE_BYTES = 8;
  localparam logic [63:0] PAD_BLOCK  = 64'h8000_0000_0000_0000;

  typedef logic [63:0] rate_block_t;

  typedef enum logic {
    FILL        = 1'b0,
    PAD_PENDING = 1'b1
  } loader_state_t;

endpackage

// File: rtl/ascon_block_loader_if.sv
// Byte-stream input side and FSM block-output side of the loader.
interface ascon_block_loader_if;
  import ascon_block_loader_pkg::*;

  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        byte_type_i;
  logic        pad_only_i;
  logic        byte_ready_o;
  logic        ready_i;
  logic        data_valid_o;
  rate_block_t block_o;
  logic        block_type_o;
  logic        block_last_o;
  logic [3:0]  valid_bytes_o;
  logic        protocol_err_o;

  modport slave (
    input  byte_i, byte_valid_i, byte_last_i, byte_type_i, pad_only_i, ready_i,
    output byte_ready_o, data_valid_o, block_o, block_type_o, block_last_o,
           valid_bytes_o, protocol_err_o
  );

  modport master (
    output byte_i, byte_valid_i, byte_last_i, byte_type_i, pad_only_i, ready_i,
    input  byte_ready_o, data_valid_o, block_o, block_type_o, block_last_o,
           valid_bytes_o, protocol_err_o
  );
endinterface

// File: rtl/ascon_block_loader_pad_lane.sv
// Ascon padding of a partial rate block: lanes below idx pass through,
// lane idx becomes 0x80, higher lanes are zeroed. idx==8 passes the block unchanged.
module ascon_pad_lane
  import ascon_block_loader_pkg::*;
(
  input  rate_block_t blk_i,
  input  logic [3:0]  idx_i,
  output rate_block_t blk_o
);

  for (genvar l = 0; l < RATE_BYTES; l++) begin : g_lane
    assign blk_o[63-8*l -: 8] = (4'(l) <  idx_i) ? blk_i[63-8*l -: 8] :
                                (4'(l) == idx_i) ? 8'h80 : 8'h00;
  end

endmodule

// File: rtl/ascon_block_loader.sv
// Ascon-128 rate-block loader: assembles bytes into padded 64-bit blocks and
// hands them to the control FSM through a one-deep output holding register.
// Optional statistics counters are enabled with ASCON_LOADER_STATS_EN.
module ascon_block_loader #(
  parameter int RATE_BYTES = 8
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  ascon_block_loader_if.slave  bus
`ifdef ASCON_LOADER_STATS_EN
  ,
  output logic [15:0]          blocks_sent_o,
  output logic [7:0]           pad_blocks_o
`endif
);
  import ascon_block_loader_pkg::*;

  if (RATE_BYTES != 8) begin : g_bad_rate
    $error("ascon_block_loader: RATE_BYTES must be 8 for Ascon-128");
  end

  loader_state_t state_q, state_d;
  rate_block_t   asm_q, asm_d, out_q, out_d, blk_q, blk_d;
  logic [3:0]    idx_q, idx_d, asm_vb_q, asm_vb_d, out_vb_q, out_vb_d, bv_q, bv_d;
  logic          asm_full_q, asm_full_d, asm_type_q, asm_type_d, asm_last_q, asm_last_d;
  logic          out_full_q, out_full_d, out_type_q, out_type_d, out_last_q, out_last_d;
  logic          pad_q, pad_d, pad_type_q, pad_type_d;
  logic          wait_low_q, wait_low_d, err_q, err_d;
  logic          dv_q, dv_d, bt_q, bt_d, bl_q, bl_d;

  logic          fire, move, byte_ready, acc, typ;
  logic [3:0]    n_bytes;
  logic [5:0]    shamt;
  rate_block_t   base, wr, padded;

  assign fire       = out_full_q && bus.ready_i && !wait_low_q;
  assign move       = asm_full_q && (!out_full_q || fire);
  assign byte_ready = (state_q == FILL) && !(asm_full_q && out_full_q);
  assign acc        = bus.byte_valid_i && byte_ready && !bus.pad_only_i;
  assign n_bytes    = idx_q + 4'd1;
  // lane k sits at bit offset 8*(7-k); ~k equals 7-k for a 3-bit lane index
  assign shamt      = {~idx_q[2:0], 3'b000};
  // a byte accepted while a completed block leaves starts a fresh assembly
  assign base       = move ? '0 : asm_q;
  assign wr         = base | ({56'h0, bus.byte_i} << shamt);

  ascon_pad_lane u_pad (
    .blk_i (wr),
    .idx_i (n_bytes),
    .blk_o (padded)
  );

  // Next state: output handshake, assembly drain, pad insertion, byte intake
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;      idx_d      = idx_q;      asm_full_d = asm_full_q;
    asm_type_d = asm_type_q; asm_last_d = asm_last_q; asm_vb_d   = asm_vb_q;
    pad_d      = pad_q;      pad_type_d = pad_type_q;
    out_d      = out_q;      out_full_d = out_full_q; out_type_d = out_type_q;
    out_last_d = out_last_q; out_vb_d   = out_vb_q;
    dv_d       = fire;       blk_d      = blk_q;      bt_d       = bt_q;
    bl_d       = bl_q;       bv_d       = bv_q;
    wait_low_d = wait_low_q; err_d      = err_q;
    typ        = (idx_q == 4'd0) ? bus.byte_type_i : asm_type_q;

    if (fire) begin
      blk_d = out_q; bt_d = out_type_q; bl_d = out_last_q; bv_d = out_vb_q;
      out_full_d = 1'b0;
      wait_low_d = 1'b1;
    end else if (!bus.ready_i) begin
      wait_low_d = 1'b0;
    end

    if (move) begin
      out_d = asm_q; out_type_d = asm_type_q; out_last_d = asm_last_q;
      out_vb_d = asm_vb_q; out_full_d = 1'b1;
      asm_d = '0; asm_full_d = 1'b0; asm_vb_d = 4'd0; asm_last_d = 1'b0;
    end

    if (state_q == PAD_PENDING) begin
      if (pad_q && (!asm_full_q || move)) begin
        asm_d = PAD_BLOCK; asm_full_d = 1'b1; asm_vb_d = 4'd0;
        asm_last_d = 1'b1; asm_type_d = pad_type_q; pad_d = 1'b0;
      end else if (!pad_q && move) begin
        state_d = FILL;
      end
    end else if (bus.pad_only_i) begin
      if (bus.byte_valid_i) err_d = 1'b1;
      if (idx_q == 4'd0) begin
        state_d = PAD_PENDING; pad_d = 1'b1; pad_type_d = bus.byte_type_i;
      end else begin
        err_d = 1'b1;
      end
    end else if (acc) begin
      if (idx_q != 4'd0 && bus.byte_type_i != asm_type_q) err_d = 1'b1;
      asm_type_d = typ;
      if (idx_q == 4'd7) begin
        asm_d = wr; asm_full_d = 1'b1; asm_vb_d = 4'd8; asm_last_d = 1'b0; idx_d = 4'd0;
        if (bus.byte_last_i) begin
          state_d = PAD_PENDING; pad_d = 1'b1; pad_type_d = typ;
        end
      end else if (bus.byte_last_i) begin
        asm_d = padded; asm_full_d = 1'b1; asm_vb_d = n_bytes; asm_last_d = 1'b1; idx_d = 4'd0;
      end else begin
        asm_d = wr; idx_d = n_bytes;
      end
    end
  end

  // State registers, cleared asynchronously; partial blocks and pending pads are dropped
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= FILL;
      asm_q    <= '0;   idx_q    <= '0;   asm_full_q <= 1'b0; asm_type_q <= 1'b0;
      asm_last_q <= 1'b0; asm_vb_q <= '0; pad_q <= 1'b0;      pad_type_q <= 1'b0;
      out_q    <= '0;   out_full_q <= 1'b0; out_type_q <= 1'b0; out_last_q <= 1'b0;
      out_vb_q <= '0;   dv_q     <= 1'b0; blk_q <= '0;        bt_q <= 1'b0;
      bl_q     <= 1'b0; bv_q     <= '0;   wait_low_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;    idx_q    <= idx_d;    asm_full_q <= asm_full_d; asm_type_q <= asm_type_d;
      asm_last_q <= asm_last_d; asm_vb_q <= asm_vb_d; pad_q <= pad_d;       pad_type_q <= pad_type_d;
      out_q    <= out_d;    out_full_q <= out_full_d; out_type_q <= out_type_d; out_last_q <= out_last_d;
      out_vb_q <= out_vb_d; dv_q     <= dv_d;     blk_q <= blk_d;         bt_q <= bt_d;
      bl_q     <= bl_d;     bv_q     <= bv_d;     wait_low_q <= wait_low_d; err_q <= err_d;
    end
  end

  assign bus.byte_ready_o   = byte_ready;
  assign bus.data_valid_o   = dv_q;
  assign bus.block_o        = blk_q;
  assign bus.block_type_o   = bt_q;
  assign bus.block_last_o   = bl_q;
  assign bus.valid_bytes_o  = bv_q;
  assign bus.protocol_err_o = err_q;

`ifdef ASCON_LOADER_STATS_EN
  logic [15:0] sent_q, sent_d;
  logic [7:0]  padc_q, padc_d;

  // Counters advance on each block handed to the FSM
  always_comb begin
    sent_d = sent_q;
    padc_d = padc_q;
    if (fire) begin
      sent_d = sent_q + 16'd1;
      if (out_vb_q == 4'd0 && padc_q != 8'hFF) padc_d = padc_q + 8'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      sent_q <= '0;
      padc_q <= '0;
    end else begin
      sent_q <= sent_d;
      padc_q <= padc_d;
    end
  end

  assign blocks_sent_o = sent_q;
  assign pad_blocks_o  = padc_q;
`endif

endmodule

// File: tb/tb_ascon_block_loader.sv
// Scoreboard bench for ascon_block_loader: a byte-level reference model pushes
// expected blocks, a monitor pops and compares on every data_valid_o pulse.
module tb_ascon_block_loader;
  import ascon_block_loader_pkg::*;

  typedef struct packed {
    logic [63:0] blk;
    logic        typ;
    logic        last;
    logic [3:0]  vb;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  ascon_block_loader_if bus();
`ifdef ASCON_LOADER_STATS_EN
  logic [15:0] blocks_sent;
  logic [7:0]  pad_blocks;
`endif

  ascon_block_loader #(.RATE_BYTES(8)) dut (
    .clock_i  (clk),
    .resetb_i (rstb),
    .bus      (bus)
`ifdef ASCON_LOADER_STATS_EN
    ,
    .blocks_sent_o (blocks_sent),
    .pad_blocks_o  (pad_blocks)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   acc_cnt = 0;
  exp_t expq[$];
  logic [7:0] cur[$];
  logic cur_type = 1'b0;
  exp_t mon_e;
  logic rdy_auto = 1'b1;
  logic rdy_man  = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Close the current block: data bytes, then 0x80 if room, zeros after.
  function automatic void push_blk(input logic last);
    exp_t e;
    int n = cur.size();
    e.blk = '0;
    for (int i = 0; i < n; i++) e.blk[63-8*i -: 8] = cur[i];
    if (n < 8) e.blk[63-8*n -: 8] = 8'h80;
    e.typ = cur_type;
    e.last = last;
    e.vb = 4'(n);
    expq.push_back(e);
    cur.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic last, input logic typ);
    if (cur.size() == 0) cur_type = typ;
    cur.push_back(b);
    acc_cnt++;
    if (last) begin
      if (cur.size() == 8) push_blk(1'b0);
      push_blk(1'b1);
    end else if (cur.size() == 8) begin
      push_blk(1'b0);
    end
  endfunction

  // FSM stand-in: random ready level, or a fixed level set by the main thread
  always @(negedge clk) begin
    if (rdy_auto) bus.ready_i = ($urandom_range(0, 3) != 0);
    else          bus.ready_i = rdy_man;
  end

  // Monitor: every consumed block is matched against the scoreboard head
  always @(negedge clk) begin
    if (rstb && bus.data_valid_o) begin
      pulses++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %h vb=%0d with empty scoreboard",
                 bus.block_o, bus.valid_bytes_o);
      end else begin
        mon_e = expq.pop_front();
        chk("block", 72'({bus.block_o, bus.block_type_o, bus.block_last_o, bus.valid_bytes_o}),
            72'(mon_e));
      end
    end
  end

  // Entered at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b, input logic last, input logic typ);
    int n = 0;
    bus.byte_i = b; bus.byte_valid_i = 1'b1; bus.byte_last_i = last; bus.byte_type_i = typ;
    while (!bus.byte_ready_o && n < 300) begin @(negedge clk); n++; end
    if (!bus.byte_ready_o) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte_ready_o stayed %0b, required 1", bus.byte_ready_o);
    end else begin
      model_byte(b, last, typ);
    end
    @(negedge clk);
    bus.byte_valid_i = 1'b0; bus.byte_last_i = 1'b0;
  endtask

  task automatic send_phase(input int len, input logic typ);
    for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1, typ);
  endtask

  task automatic pad_req(input logic typ, input logic expect_ok);
    int n = 0;
    while (!bus.byte_ready_o && n < 300) begin @(negedge clk); n++; end
    bus.pad_only_i = 1'b1; bus.byte_type_i = typ;
    if (expect_ok) begin cur_type = typ; push_blk(1'b1); end
    @(negedge clk);
    bus.pad_only_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d blocks pending, required 0", expq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dv"},   72'(bus.data_valid_o), 72'(0));
    chk({tag, "_blk"},  72'(bus.block_o), 72'(0));
    chk({tag, "_vb"},   72'(bus.valid_bytes_o), 72'(0));
    chk({tag, "_last"}, 72'(bus.block_last_o), 72'(0));
    chk({tag, "_type"}, 72'(bus.block_type_o), 72'(0));
    chk({tag, "_err"},  72'(bus.protocol_err_o), 72'(0));
  endtask

  initial begin
    int p0, a0;
    logic [7:0] ascon [5];
    ascon = '{8'h41, 8'h53, 8'h43, 8'h4F, 8'h4E};
    bus.byte_i = '0; bus.byte_valid_i = 1'b0; bus.byte_last_i = 1'b0;
    bus.byte_type_i = 1'b0; bus.pad_only_i = 1'b0; bus.ready_i = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstb = 1'b1;
    @(negedge clk);

    // "ASCON" AD phase
    p0 = pulses;
    for (int i = 0; i < 5; i++) send(ascon[i], i == 4, 1'b0);
    drain();
    chk("ascon_pulses", 72'(pulses - p0), 72'(1));

    // 8 plaintext bytes: full block then pad-only block
    for (int i = 0; i < 8; i++) begin
      send(8'(i), i == 7, 1'b1);
      if (i == 7) chk("pad_pending_ready", 72'(bus.byte_ready_o), 72'(0));
    end
    drain();

    // 20 bytes with the FSM not ready: intake stalls after both buffers fill
    rdy_auto = 1'b0; rdy_man = 1'b0;
    repeat (2) @(negedge clk);
    a0 = acc_cnt; p0 = pulses;
    fork
      send_phase(20, 1'b0);
      begin
        repeat (30) @(negedge clk);
        chk("stall_count", 72'(acc_cnt - a0), 72'(16));
        chk("stall_ready", 72'(bus.byte_ready_o), 72'(0));
        chk("stall_nopulse", 72'(pulses - p0), 72'(0));
        rdy_auto = 1'b1;
      end
    join
    drain();

    // Two buffered blocks, ready held high: one pulse until ready drops
    rdy_auto = 1'b0; rdy_man = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), i == 7, 1'b0);
    repeat (4) @(negedge clk);
    p0 = pulses;
    rdy_man = 1'b1;
    repeat (7) @(negedge clk);
    chk("hold_high_one_pulse", 72'(pulses - p0), 72'(1));
    rdy_man = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_low_no_pulse", 72'(pulses - p0), 72'(1));
    rdy_man = 1'b1;
    repeat (4) @(negedge clk);
    chk("second_pulse", 72'(pulses - p0), 72'(2));
    rdy_auto = 1'b1;
    drain();

    // pad_only at idx 0, then at idx 3 (protocol error, ignored)
    chk("err_clear", 72'(bus.protocol_err_o), 72'(0));
    pad_req(1'b1, 1'b1);
    drain();
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
    pad_req(1'b1, 1'b0);
    chk("err_pad_mid", 72'(bus.protocol_err_o), 72'(1));
    send(8'h13, 1'b1, 1'b0);
    drain();
    chk("err_sticky", 72'(bus.protocol_err_o), 72'(1));

    // Randomized phases
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) pad_req(1'($urandom), 1'b1);
      else send_phase($urandom_range(1, 20), 1'($urandom));
    end
    drain();

    // Reset mid-block (idx 4)
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b1);
    #2 rstb = 1'b0;
    #1 check_reset_outputs("rst_mid");
    expq.delete(); cur.delete();
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    send_phase(3, 1'b0);
    drain();

    // Reset while a pad block is pending
    rdy_auto = 1'b0; rdy_man = 1'b0;
    repeat (2) @(negedge clk);
    send_phase(8, 1'b1);
    chk("pad_pending_before_rst", 72'(bus.byte_ready_o), 72'(0));
    #2 rstb = 1'b0;
    #1 check_reset_outputs("rst_pad");
    expq.delete(); cur.delete();
    @(negedge clk);
    rstb = 1'b1;
    rdy_auto = 1'b1;
    @(negedge clk);
    p0 = pulses;
    send(8'h5A, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    drain();
    repeat (20) @(negedge clk);
    chk("no_stale_pad", 72'(pulses - p0), 72'(1));

    chk("scoreboard_empty", 72'(expq.size()), 72'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
